// File: rtl/ulx3s_spi_pkg.sv
// ulx3s_spi_pkg
// Shared definitions for the ULX3S OLED/button SPI initiator:
//   - spi_state_t        : frame sequencing FSM states
//   - C_CLK_DIV_DEFAULT  : default SCK half-period in clk_25mhz cycles
//   - C_CSN_IDLE_DEFAULT : default minimum CSn-high gap between frames
//   - DC_COMMAND/DC_DATA : levels driven on the OLED D/C pin
package ulx3s_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,  // CSn high, ready for a new frame
    ST_SHIFT = 3'd1,  // clocking one byte out/in (16 half-periods)
    ST_HOLD  = 3'd2,  // CSn low between bytes of one frame
    ST_TRAIL = 3'd3,  // one SCK-low half-period before CSn rises
    ST_GAP   = 3'd4   // CSn high, enforcing the inter-frame idle time
  } spi_state_t;

  localparam int C_CLK_DIV_DEFAULT  = 2;
  localparam int C_CSN_IDLE_DEFAULT = 4;

  localparam logic DC_COMMAND = 1'b0;
  localparam logic DC_DATA    = 1'b1;

endpackage

// File: rtl/spi_half_tick.sv
// spi_half_tick
// Loadable down-counter that emits a one-cycle tick every C_clk_div cycles
// while enabled. A restart reloads the counter so the first tick lands
// exactly C_clk_div cycles after the restart cycle.
// Ports:
//   clk_25mhz : system clock
//   resetn    : asynchronous active-low reset
//   restart   : reload the counter (frame/byte start)
//   enable    : count while high
//   tick      : one-cycle half-period strobe
module spi_half_tick
  import ulx3s_spi_pkg::*;
#(
  parameter int C_clk_div = C_CLK_DIV_DEFAULT
) (
  input  logic clk_25mhz,
  input  logic resetn,
  input  logic restart,
  input  logic enable,
  output logic tick
);

  localparam int            CW     = $clog2(C_clk_div) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(C_clk_div - 1);
  localparam logic [CW-1:0] ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic [CW-1:0] cnt_r;
  logic          cnt_zero_s;

  assign cnt_zero_s = (cnt_r == ZERO);
  assign tick       = enable & cnt_zero_s;

  // Half-period down-counter: reload on restart and on every tick.
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      cnt_r <= RELOAD;
    end else if (restart) begin
      cnt_r <= RELOAD;
    end else if (enable) begin
      if (cnt_zero_s) begin
        cnt_r <= RELOAD;
      end else begin
        cnt_r <= cnt_r - ONE;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/oled_spi_master.sv
// oled_spi_master
// SPI mode-0 initiator for the ULX3S OLED/button bus. Bytes offered on a
// valid/ready handshake are shifted out MSB first on spi_mosi while the
// responder's spi_miso is sampled into rx_data. tx_last closes the frame.
// Ports:
//   clk_25mhz, resetn              : clock, asynchronous active-low reset
//   tx_data/tx_dc/tx_last          : byte, D/C level, end-of-frame flag
//   tx_valid/tx_ready              : input handshake
//   rx_data/rx_valid               : received byte, one-cycle strobe
//   busy                           : CSn low or inter-frame gap running
//   spi_csn/spi_clk/spi_mosi/spi_dc: SPI pins (all registered)
//   spi_miso                       : responder data
module oled_spi_master
  import ulx3s_spi_pkg::*;
#(
  parameter int C_clk_div  = C_CLK_DIV_DEFAULT,
  parameter int C_csn_idle = C_CSN_IDLE_DEFAULT
) (
  input  logic       clk_25mhz,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_dc,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       spi_csn,
  output logic       spi_clk,
  output logic       spi_mosi,
  output logic       spi_dc,
  input  logic       spi_miso
);

  localparam int            GW       = $clog2(C_csn_idle) + 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(C_csn_idle - 1);
  localparam logic [GW-1:0] GAP_ZERO = {GW{1'b0}};
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  spi_state_t  state_r;
  spi_state_t  next_state_s;

  logic [2:0]    bit_cnt_r;
  logic [6:0]    tx_shift_r;   // bits still to be sent after the one on MOSI
  logic [7:0]    rx_shift_r;
  logic          last_r;
  logic [GW-1:0] gap_cnt_r;

  logic          tx_ready_r;
  logic [7:0]    rx_data_r;
  logic          rx_valid_r;
  logic          busy_r;
  logic          spi_csn_r;
  logic          spi_clk_r;
  logic          spi_mosi_r;
  logic          spi_dc_r;

  logic          accept_s;
  logic          tick_s;
  logic          tick_en_s;
  logic          shift_tick_s;
  logic          rise_s;
  logic          fall_s;
  logic          byte_done_s;
  logic          gap_done_s;

  // tx_ready is registered and only ever high in IDLE/HOLD, so it alone
  // qualifies an accept.
  assign accept_s     = tx_valid & tx_ready_r;
  assign tick_en_s    = (state_r == ST_SHIFT) | (state_r == ST_TRAIL);
  assign shift_tick_s = (state_r == ST_SHIFT) & tick_s;
  assign rise_s       = shift_tick_s & ~spi_clk_r;
  assign fall_s       = shift_tick_s & spi_clk_r;
  assign byte_done_s  = fall_s & (bit_cnt_r == 3'd7);
  assign gap_done_s   = (gap_cnt_r == GAP_ZERO);

  spi_half_tick #(
    .C_clk_div (C_clk_div)
  ) u_half_tick (
    .clk_25mhz (clk_25mhz),
    .resetn    (resetn),
    .restart   (accept_s),
    .enable    (tick_en_s),
    .tick      (tick_s)
  );

  // FSM state register.
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = ST_SHIFT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (byte_done_s) begin
          if (last_r) begin
            next_state_s = ST_TRAIL;
          end else begin
            next_state_s = ST_HOLD;
          end
        end else begin
          next_state_s = ST_SHIFT;
        end
      end
      ST_HOLD: begin
        if (accept_s) begin
          next_state_s = ST_SHIFT;
        end else begin
          next_state_s = ST_HOLD;
        end
      end
      ST_TRAIL: begin
        if (tick_s) begin
          next_state_s = ST_GAP;
        end else begin
          next_state_s = ST_TRAIL;
        end
      end
      ST_GAP: begin
        if (gap_done_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_GAP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Status outputs derived from the upcoming state so they line up with CSn.
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      tx_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      spi_csn_r  <= 1'b1;
    end else begin
      tx_ready_r <= (next_state_s == ST_IDLE) | (next_state_s == ST_HOLD);
      busy_r     <= (next_state_s != ST_IDLE);
      spi_csn_r  <= (next_state_s == ST_IDLE) | (next_state_s == ST_GAP);
    end
  end

  // Inter-frame gap counter: loaded as CSn rises, counts down in GAP.
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      gap_cnt_r <= GAP_ZERO;
    end else if ((state_r == ST_TRAIL) && tick_s) begin
      gap_cnt_r <= GAP_LOAD;
    end else if ((state_r == ST_GAP) && !gap_done_s) begin
      gap_cnt_r <= gap_cnt_r - GAP_ONE;
    end else begin
      gap_cnt_r <= gap_cnt_r;
    end
  end

  // Byte datapath: latch on accept, toggle SCK on ticks, shift MOSI on the
  // falling edge and capture MISO on the rising edge.
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      bit_cnt_r  <= 3'd0;
      tx_shift_r <= 7'd0;
      rx_shift_r <= 8'd0;
      last_r     <= 1'b0;
      rx_data_r  <= 8'd0;
      rx_valid_r <= 1'b0;
      spi_clk_r  <= 1'b0;
      spi_mosi_r <= 1'b0;
      spi_dc_r   <= DC_COMMAND;
    end else begin
      rx_valid_r <= 1'b0;
      if (accept_s) begin
        // An accept can coincide with the previous byte's rx_valid; that
        // pulse was already registered on the prior edge, so nothing is lost.
        bit_cnt_r  <= 3'd0;
        tx_shift_r <= tx_data[6:0];
        spi_mosi_r <= tx_data[7];
        spi_dc_r   <= tx_dc;
        last_r     <= tx_last;
        spi_clk_r  <= 1'b0;
      end else if (rise_s) begin
        spi_clk_r  <= 1'b1;
        rx_shift_r <= {rx_shift_r[6:0], spi_miso};
      end else if (fall_s) begin
        spi_clk_r <= 1'b0;
        if (byte_done_s) begin
          rx_data_r  <= rx_shift_r;
          rx_valid_r <= 1'b1;
        end else begin
          bit_cnt_r  <= bit_cnt_r + 3'd1;
          spi_mosi_r <= tx_shift_r[6];
          tx_shift_r <= {tx_shift_r[5:0], 1'b0};
        end
      end else begin
        spi_clk_r <= spi_clk_r;
      end
    end
  end

  assign tx_ready = tx_ready_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign busy     = busy_r;
  assign spi_csn  = spi_csn_r;
  assign spi_clk  = spi_clk_r;
  assign spi_mosi = spi_mosi_r;
  assign spi_dc   = spi_dc_r;

endmodule

// File: tb/tb_oled_spi_master.sv
// Directed self-checking bench for oled_spi_master.
// Instance A: C_clk_div=2, C_csn_idle=4, MISO from loopback or a button model.
// Instance B: C_clk_div=1, C_csn_idle=4, MISO looped back from MOSI.
module tb_oled_spi_master;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Instance A signals
  logic [7:0] tx_data_a = 8'h00;
  logic       tx_dc_a = 1'b0, tx_last_a = 1'b0, tx_valid_a = 1'b0;
  logic       tx_ready_a, rx_valid_a, busy_a;
  logic [7:0] rx_data_a;
  logic       spi_csn_a, spi_clk_a, spi_mosi_a, spi_dc_a, spi_miso_a;

  // Instance B signals
  logic [7:0] tx_data_b = 8'h00;
  logic       tx_dc_b = 1'b0, tx_last_b = 1'b0, tx_valid_b = 1'b0;
  logic       tx_ready_b, rx_valid_b, busy_b;
  logic [7:0] rx_data_b;
  logic       spi_csn_b, spi_clk_b, spi_mosi_b, spi_dc_b;

  // Button responder model: loads while CSn high, shifts after SCK rises.
  logic       use_model = 1'b0;
  logic [7:0] model_load = 8'h00;
  logic [7:0] model_sr = 8'h00;
  logic       prev_sck_a = 1'b0;

  always @(posedge clk) begin
    prev_sck_a <= spi_clk_a;
    if (spi_csn_a) model_sr <= model_load;
    else if (spi_clk_a && !prev_sck_a) model_sr <= {model_sr[6:0], 1'b0};
  end

  assign spi_miso_a = use_model ? model_sr[7] : spi_mosi_a;

  oled_spi_master #(.C_clk_div(2), .C_csn_idle(4)) dut_a (
    .clk_25mhz(clk), .resetn(resetn),
    .tx_data(tx_data_a), .tx_dc(tx_dc_a), .tx_last(tx_last_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .busy(busy_a),
    .spi_csn(spi_csn_a), .spi_clk(spi_clk_a), .spi_mosi(spi_mosi_a), .spi_dc(spi_dc_a),
    .spi_miso(spi_miso_a)
  );

  oled_spi_master #(.C_clk_div(1), .C_csn_idle(4)) dut_b (
    .clk_25mhz(clk), .resetn(resetn),
    .tx_data(tx_data_b), .tx_dc(tx_dc_b), .tx_last(tx_last_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .busy(busy_b),
    .spi_csn(spi_csn_b), .spi_clk(spi_clk_b), .spi_mosi(spi_mosi_b), .spi_dc(spi_dc_b),
    .spi_miso(spi_mosi_b)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready_a(input string tag);
    int k;
    k = 0;
    while (!tx_ready_a && k < 100) begin
      step();
      k++;
    end
    tests_run++;
    if (tx_ready_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s: tx_ready wait timed out, got %b expected 1", tag, tx_ready_a);
    end
  endtask

  // Present one byte on A for its accept edge; returns in cycle T+1.
  task automatic send_a(input logic [7:0] d, input logic dc, input logic last);
    tx_data_a = d; tx_dc_a = dc; tx_last_a = last; tx_valid_a = 1'b1;
    step();
    tx_valid_a = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) step();
    tests_run++;
    if ({spi_csn_a, spi_clk_a, spi_mosi_a, spi_dc_a} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL reset_pins: got csn/clk/mosi/dc=%b expected 1000", {spi_csn_a, spi_clk_a, spi_mosi_a, spi_dc_a});
    end
    tests_run++;
    if ({tx_ready_a, rx_valid_a, busy_a, rx_data_a} !== 11'h000) begin
      tests_failed++;
      $display("FAIL reset_status: got ready/rxv/busy/rxd=%b %b %b %h expected 0 0 0 00", tx_ready_a, rx_valid_a, busy_a, rx_data_a);
    end
    resetn = 1'b1;
    step();
    tests_run++;
    if (tx_ready_a !== 1'b1 || tx_ready_b !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready_rise: got %b %b expected 1 1", tx_ready_a, tx_ready_b);
    end
  endtask

  task automatic test_loopback();
    int rises, csn_low, rx_n, first_rise, csn_up, pulses;
    logic prev, ready38, ready39;
    logic [7:0] rxd;
    use_model = 1'b0;
    wait_ready_a("loop_ready");
    send_a(8'hA5, 1'b1, 1'b1);
    tests_run++;
    if ({spi_csn_a, spi_mosi_a, spi_dc_a} !== 3'b011) begin
      tests_failed++;
      $display("FAIL loop_start: got csn/mosi/dc=%b expected 011", {spi_csn_a, spi_mosi_a, spi_dc_a});
    end
    rises = 0; csn_low = 0; rx_n = -1; first_rise = -1; csn_up = -1; pulses = 0;
    prev = 1'b0; ready38 = 1'bx; ready39 = 1'bx; rxd = 8'h00;
    for (int n = 1; n <= 40; n++) begin
      if (spi_clk_a && !prev) begin
        rises++;
        if (first_rise < 0) first_rise = n;
      end
      prev = spi_clk_a;
      if (!spi_csn_a) csn_low++;
      else if (csn_up < 0) csn_up = n;
      if (rx_valid_a) begin rx_n = n; rxd = rx_data_a; pulses++; end
      if (n == 38) ready38 = tx_ready_a;
      if (n == 39) ready39 = tx_ready_a;
      step();
    end
    tests_run++;
    if (rises != 8) begin tests_failed++; $display("FAIL loop_rises: got %0d expected 8", rises); end
    tests_run++;
    if (first_rise != 3) begin tests_failed++; $display("FAIL loop_first_rise: got T+%0d expected T+3", first_rise); end
    tests_run++;
    if (rx_n != 33 || pulses != 1) begin tests_failed++; $display("FAIL loop_rx_time: got T+%0d x%0d expected T+33 x1", rx_n, pulses); end
    tests_run++;
    if (rxd !== 8'hA5) begin tests_failed++; $display("FAIL loop_rx_data: got %h expected a5", rxd); end
    tests_run++;
    if (csn_low != 34 || csn_up != 35) begin
      tests_failed++;
      $display("FAIL loop_csn: got low %0d cycles, high at T+%0d expected 34, T+35", csn_low, csn_up);
    end
    tests_run++;
    if (ready38 !== 1'b0 || ready39 !== 1'b1) begin
      tests_failed++;
      $display("FAIL loop_gap_ready: got %b%b expected 01", ready38, ready39);
    end
  endtask

  task automatic test_burst();
    logic [7:0] bytes [3];
    logic       dcs [3];
    logic [7:0] rxv [3];
    logic       dcv [3];
    int         rxn [3];
    int         idx, rx_cnt, csn_breaks, n;
    logic       acc;
    bytes = '{8'h15, 8'h00, 8'h5F};
    dcs = '{1'b0, 1'b1, 1'b1};
    use_model = 1'b0;
    wait_ready_a("burst_ready");
    idx = 0; rx_cnt = 0; csn_breaks = 0; n = 0;
    tx_data_a = bytes[0]; tx_dc_a = dcs[0]; tx_last_a = 1'b0; tx_valid_a = 1'b1;
    for (int c = 0; c < 150 && rx_cnt < 3; c++) begin
      acc = tx_valid_a && tx_ready_a;
      step();
      n++;
      if (acc) begin
        idx++;
        if (idx < 3) begin
          tx_data_a = bytes[idx]; tx_dc_a = dcs[idx]; tx_last_a = (idx == 2);
        end else begin
          tx_valid_a = 1'b0;
        end
      end
      if (idx > 0 && spi_csn_a) csn_breaks++;
      if (rx_valid_a) begin
        rxv[rx_cnt] = rx_data_a; dcv[rx_cnt] = spi_dc_a; rxn[rx_cnt] = n; rx_cnt++;
      end
    end
    tx_valid_a = 1'b0;
    tests_run++;
    if (rx_cnt != 3) begin tests_failed++; $display("FAIL burst_pulses: got %0d expected 3", rx_cnt); end
    tests_run++;
    if (csn_breaks != 0) begin tests_failed++; $display("FAIL burst_csn: got %0d high cycles expected 0", csn_breaks); end
    for (int k = 0; k < rx_cnt; k++) begin
      tests_run++;
      if (rxv[k] !== bytes[k] || dcv[k] !== dcs[k] || rxn[k] != 33 * (k + 1)) begin
        tests_failed++;
        $display("FAIL burst_byte%0d: got %h dc=%b at T+%0d expected %h dc=%b at T+%0d",
                 k, rxv[k], dcv[k], rxn[k], bytes[k], dcs[k], 33 * (k + 1));
      end
    end
  endtask

  task automatic test_responder();
    logic [7:0] pats [8];
    int k;
    pats = '{8'h7F, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h55, 8'hAA, 8'h3C};
    use_model = 1'b1;
    for (int p = 0; p < 8; p++) begin
      model_load = pats[p];
      wait_ready_a("resp_ready");
      step();
      send_a(8'h00, 1'b0, 1'b1);
      k = 0;
      while (!rx_valid_a && k < 60) begin step(); k++; end
      tests_run++;
      if (rx_valid_a !== 1'b1 || rx_data_a !== pats[p]) begin
        tests_failed++;
        $display("FAIL resp_pattern%0d: got %h (valid=%b) expected %h", p, rx_data_a, rx_valid_a, pats[p]);
      end
    end
    use_model = 1'b0;
  endtask

  task automatic test_reset_midbyte();
    int pulses, csn_lows, k;
    use_model = 1'b0;
    wait_ready_a("rst_ready");
    send_a(8'hC3, 1'b1, 1'b1);
    repeat (13) step();  // cycle T+14, inside bit 3
    #2;
    resetn = 1'b0;
    #1;
    tests_run++;
    if ({spi_csn_a, spi_clk_a, spi_mosi_a, spi_dc_a} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL rst_mid_pins: got csn/clk/mosi/dc=%b expected 1000", {spi_csn_a, spi_clk_a, spi_mosi_a, spi_dc_a});
    end
    tests_run++;
    if ({tx_ready_a, busy_a, rx_valid_a, rx_data_a} !== 11'h000) begin
      tests_failed++;
      $display("FAIL rst_mid_status: got ready/busy/rxv/rxd=%b %b %b %h expected 0 0 0 00", tx_ready_a, busy_a, rx_valid_a, rx_data_a);
    end
    step();
    step();
    resetn = 1'b1;
    step();
    tests_run++;
    if (tx_ready_a !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_ready: got %b expected 1", tx_ready_a); end
    pulses = 0; csn_lows = 0;
    for (int n = 0; n < 40; n++) begin
      if (rx_valid_a) pulses++;
      if (!spi_csn_a) csn_lows++;
      step();
    end
    tests_run++;
    if (pulses != 0 || csn_lows != 0) begin
      tests_failed++;
      $display("FAIL rst_mid_abort: got %0d pulses %0d low cycles expected 0 0", pulses, csn_lows);
    end
    send_a(8'h3C, 1'b0, 1'b1);
    k = 1;
    while (!rx_valid_a && k < 60) begin step(); k++; end
    tests_run++;
    if (rx_data_a !== 8'h3C || k != 33) begin
      tests_failed++;
      $display("FAIL rst_mid_next: got %h at T+%0d expected 3c at T+33", rx_data_a, k);
    end
  endtask

  task automatic test_valid_in_shift();
    int stolen, rx_n, late_low, csn_up;
    logic [7:0] rxd;
    logic dcv;
    use_model = 1'b0;
    wait_ready_a("sv_ready");
    send_a(8'h96, 1'b1, 1'b1);
    stolen = 0; rx_n = -1; late_low = 0; csn_up = -1; rxd = 8'h00; dcv = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      if (n >= 5 && n <= 20) begin
        tx_valid_a = 1'b1; tx_data_a = 8'hFF; tx_dc_a = 1'b0; tx_last_a = 1'b0;
        if (tx_ready_a) stolen++;
      end else begin
        tx_valid_a = 1'b0;
      end
      if (rx_valid_a) begin rx_n = n; rxd = rx_data_a; dcv = spi_dc_a; end
      if (spi_csn_a && csn_up < 0) csn_up = n;
      if (n > 35 && !spi_csn_a) late_low++;
      step();
    end
    tests_run++;
    if (stolen != 0) begin tests_failed++; $display("FAIL sv_ready_low: got %0d ready cycles expected 0", stolen); end
    tests_run++;
    if (rxd !== 8'h96 || rx_n != 33 || dcv !== 1'b1) begin
      tests_failed++;
      $display("FAIL sv_byte: got %h dc=%b at T+%0d expected 96 dc=1 at T+33", rxd, dcv, rx_n);
    end
    tests_run++;
    if (csn_up != 35 || late_low != 0) begin
      tests_failed++;
      $display("FAIL sv_no_queue: got csn up T+%0d, %0d later low cycles expected T+35, 0", csn_up, late_low);
    end
  endtask

  task automatic test_div1_back_to_back();
    int accepts, rises, bad_period, last_rise, rx_cnt, gap_high, gap_busy, ready_in_gap, k;
    logic prev;
    logic [7:0] rxv [2];
    k = 0;
    while (!tx_ready_b && k < 100) begin step(); k++; end
    accepts = 0; rises = 0; bad_period = 0; last_rise = -1; rx_cnt = 0;
    gap_high = 0; gap_busy = 0; ready_in_gap = 0; prev = 1'b0;
    rxv = '{8'h00, 8'h00};
    tx_data_b = 8'h81; tx_dc_b = 1'b1; tx_last_b = 1'b1; tx_valid_b = 1'b1;
    for (int n = 0; n < 80 && rx_cnt < 2; n++) begin
      if (tx_valid_b && tx_ready_b) begin
        step();
        accepts++;
        if (accepts == 1) tx_data_b = 8'h7E;
        else tx_valid_b = 1'b0;
      end else begin
        step();
      end
      if (spi_clk_b && !prev) begin
        if (last_rise >= 0 && (n + 1 - last_rise) != 2) bad_period++;
        last_rise = n + 1;
        rises++;
      end
      prev = spi_clk_b;
      if (rx_valid_b) begin rxv[rx_cnt] = rx_data_b; rx_cnt++; last_rise = -1; end
      if (accepts == 1 && rx_cnt == 1 && spi_csn_b) begin
        gap_high++;
        if (busy_b) begin
          gap_busy++;
          if (tx_ready_b) ready_in_gap++;
        end
      end
    end
    tx_valid_b = 1'b0;
    tests_run++;
    if (rises != 16 || bad_period != 0) begin
      tests_failed++;
      $display("FAIL div1_sck: got %0d rises, %0d bad periods expected 16, 0", rises, bad_period);
    end
    tests_run++;
    if (gap_high < 4 || gap_busy != 4) begin
      tests_failed++;
      $display("FAIL div1_gap: got %0d high, %0d busy cycles expected >=4, 4", gap_high, gap_busy);
    end
    tests_run++;
    if (ready_in_gap != 0) begin tests_failed++; $display("FAIL div1_gap_ready: got %0d expected 0", ready_in_gap); end
    tests_run++;
    if (rx_cnt != 2 || rxv[0] !== 8'h81 || rxv[1] !== 8'h7E) begin
      tests_failed++;
      $display("FAIL div1_data: got %0d bytes %h %h expected 2 bytes 81 7e", rx_cnt, rxv[0], rxv[1]);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_burst();
    test_responder();
    test_reset_midbyte();
    test_valid_in_shift();
    test_div1_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
